module_arbitro_registro: RTL and testbench

MODULE_ARBITRO_REGISTRO -- requirements
Module: module_arbitro_registro

---
 rtl/module_arbitro_registro.sv | 128 ++++++++++++
 tb/tb_module_arbitro_registro.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_arbitro_registro.sv
// Two-requester write arbiter in front of a shared external register.
// Each granted write is driven for one cycle (dp_ce), read back through dp_q
// one cycle later, and acknowledged to its requester with a one-cycle pulse.
// A read-back mismatch sets a sticky err flag that only rst clears.
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> simultaneous requests alternate, starting with A
//                   undefined -> fixed priority, A always wins a tie
module module_arbitro_registro #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [DW-1:0] dat_a,
  output logic          ack_a,
  input  logic          req_b,
  input  logic [DW-1:0] dat_b,
  output logic          ack_b,
  output logic [DW-1:0] dp_d,
  output logic          dp_ce,
  input  logic [DW-1:0] dp_q,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          grant_b;
  logic          accept;
  logic [DW-1:0] grant_dat;
  logic [DW-1:0] hold;

  // Arbitration: pick the requester that would be granted if IDLE accepts now
  always_comb begin
    grant_b = 1'b0;
    if (req_a && req_b) begin
`ifdef ROUND_ROBIN_EN
      // owner resets to B, so the first tie after reset goes to A
      grant_b = ~owner;
`else
      grant_b = 1'b0;
`endif
    end else begin
      grant_b = req_b;
    end
  end

  // Data of the requester being granted, captured only at the acceptance edge
  always_comb begin
    grant_dat = dat_a;
    if (grant_b) begin
      grant_dat = dat_b;
    end
  end

  // Next-state logic; every transaction walks LOAD -> VERIFY -> ACK -> IDLE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_nx = LOAD;
          accept   = 1'b1;
        end
      end
      LOAD:    state_nx = VERIFY;
      VERIFY:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered control outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      dp_ce <= 1'b0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      owner <= 1'b1;
      err   <= 1'b0;
    end else begin
      busy  <= (state_nx != IDLE);
      dp_ce <= (state_nx == LOAD);
      // owner is only updated on acceptance, so it is stable through ACK
      ack_a <= (state_nx == ACK) && !owner;
      ack_b <= (state_nx == ACK) && owner;
      if (accept) begin
        owner <= grant_b;
      end
      // dp_q reflects the write committed at the end of LOAD
      if ((state == VERIFY) && (dp_q != hold)) begin
        err <= 1'b1;
      end
    end
  end

  // Hold register and data bus; dp_d keeps the last written value between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      dp_d <= '0;
    end else if (accept) begin
      hold <= grant_dat;
      dp_d <= grant_dat;
    end
  end

endmodule

// File: tb/tb_module_arbitro_registro.sv
// Self-checking bench for module_arbitro_registro: directed scenarios plus a
// randomized run scored against a transaction-schedule reference model.
module tb_module_arbitro_registro;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_a = 1'b0;
  logic [DW-1:0] dat_a = '0;
  logic          ack_a;
  logic          req_b = 1'b0;
  logic [DW-1:0] dat_b = '0;
  logic          ack_b;
  logic [DW-1:0] dp_d;
  logic          dp_ce;
  logic [DW-1:0] dp_q;
  logic          busy;
  logic          owner;
  logic          err;

  // shared external register model and read-back fault injection
  logic [DW-1:0] reg_q = '0;
  logic          force_zero = 1'b0;
  int            ce_count = 0;

  int compared = 0;
  int mismatched = 0;

  module_arbitro_registro #(.DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .dat_a (dat_a),
    .ack_a (ack_a),
    .req_b (req_b),
    .dat_b (dat_b),
    .ack_b (ack_b),
    .dp_d  (dp_d),
    .dp_ce (dp_ce),
    .dp_q  (dp_q),
    .busy  (busy),
    .owner (owner),
    .err   (err)
  );

  always #5 clk = ~clk;

  assign dp_q = force_zero ? '0 : reg_q;

  always @(posedge clk) begin
    if (dp_ce) begin
      reg_q    <= dp_d;
      ce_count <= ce_count + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; dat_a = 4'h3;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (dp_ce !== 1'b0) begin mismatched++; $display("FAIL reset_dp_ce: got %b want 0", dp_ce); end
    compared++; if (dp_d !== 4'h0) begin mismatched++; $display("FAIL reset_dp_d: got %h want 0", dp_d); end
    compared++; if ({ack_a, ack_b} !== 2'b00) begin mismatched++; $display("FAIL reset_acks: got %b want 00", {ack_a, ack_b}); end
    compared++; if (owner !== 1'b1) begin mismatched++; $display("FAIL reset_owner: got %b want 1", owner); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
    compared++; if (dp_ce !== 1'b1 || dp_d !== 4'h3) begin mismatched++; $display("FAIL first_grant: got ce=%b d=%h want ce=1 d=3", dp_ce, dp_d); end
    @(negedge clk); @(negedge clk);
    compared++; if (ack_a !== 1'b1) begin mismatched++; $display("FAIL first_ack: got %b want 1", ack_a); end
    req_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int c0;
    c0 = ce_count;
    req_a = 1'b1; dat_a = 4'b1010;
    @(negedge clk);
    compared++; if (dp_ce !== 1'b1 || dp_d !== 4'b1010) begin mismatched++; $display("FAIL single_load: got ce=%b d=%h want ce=1 d=a", dp_ce, dp_d); end
    compared++; if (busy !== 1'b1 || owner !== 1'b0) begin mismatched++; $display("FAIL single_busy_owner: got %b%b want 10", busy, owner); end
    @(negedge clk);
    compared++; if (dp_ce !== 1'b0 || ack_a !== 1'b0) begin mismatched++; $display("FAIL single_verify: got ce=%b ack=%b want 0 0", dp_ce, ack_a); end
    @(negedge clk);
    compared++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin mismatched++; $display("FAIL single_ack: got a=%b b=%b want a=1 b=0", ack_a, ack_b); end
    req_a = 1'b0;
    @(negedge clk);
    compared++; if (ack_a !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL single_idle: got ack=%b busy=%b err=%b want 0 0 0", ack_a, busy, err); end
    compared++; if (dp_d !== 4'b1010 || ce_count - c0 != 1) begin mismatched++; $display("FAIL single_hold: got d=%h pulses=%0d want d=a pulses=1", dp_d, ce_count - c0); end
  endtask

  task automatic test_mismatch();
    force_zero = 1'b1; req_a = 1'b1; dat_a = 4'b1010;
    @(negedge clk); @(negedge clk); @(negedge clk);
    compared++; if (ack_a !== 1'b1 || err !== 1'b1) begin mismatched++; $display("FAIL mismatch_flag: got ack=%b err=%b want 1 1", ack_a, err); end
    req_a = 1'b0; force_zero = 1'b0;
    @(negedge clk);
    req_b = 1'b1; dat_b = 4'b0110;
    @(negedge clk); @(negedge clk); @(negedge clk);
    compared++; if (ack_b !== 1'b1 || err !== 1'b1 || reg_q !== 4'b0110) begin mismatched++; $display("FAIL mismatch_sticky: got ack=%b err=%b q=%h want 1 1 6", ack_b, err, reg_q); end
    req_b = 1'b0;
    @(negedge clk);
    do_reset();
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL mismatch_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_in_load();
    int c0;
    bit saw_ack;
    req_a = 1'b1; dat_a = 4'b0101;
    @(negedge clk);
    c0 = ce_count;
    compared++; if (dp_ce !== 1'b1) begin mismatched++; $display("FAIL rload_ce: got %b want 1", dp_ce); end
    rst = 1'b1;
    #1;
    compared++; if (dp_ce !== 1'b0 || busy !== 1'b0 || owner !== 1'b1) begin mismatched++; $display("FAIL rload_abort: got ce=%b busy=%b owner=%b want 0 0 1", dp_ce, busy, owner); end
    req_a = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) saw_ack = 1'b1;
    end
    compared++; if (saw_ack || ce_count != c0) begin mismatched++; $display("FAIL rload_noack: got ack=%b pulses=%0d want 0 0", saw_ack, ce_count - c0); end
    req_a = 1'b1; dat_a = 4'b1001;
    @(negedge clk);
    compared++; if (dp_ce !== 1'b1 || dp_d !== 4'b1001) begin mismatched++; $display("FAIL rload_retry: got ce=%b d=%h want 1 9", dp_ce, dp_d); end
    @(negedge clk); @(negedge clk);
    compared++; if (ack_a !== 1'b1 || owner !== 1'b0) begin mismatched++; $display("FAIL rload_retry_ack: got ack=%b owner=%b want 1 0", ack_a, owner); end
    req_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_change();
    req_b = 1'b1; dat_b = 4'b0011;
    @(negedge clk);
    dat_b = 4'b1100;
    compared++; if (dp_d !== 4'b0011) begin mismatched++; $display("FAIL dchg_load: got %h want 3", dp_d); end
    @(negedge clk);
    compared++; if (reg_q !== 4'b0011) begin mismatched++; $display("FAIL dchg_reg: got %h want 3", reg_q); end
    @(negedge clk);
    compared++; if (ack_b !== 1'b1 || err !== 1'b0) begin mismatched++; $display("FAIL dchg_ack: got ack=%b err=%b want 1 0", ack_b, err); end
    req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic [DW-1:0] wr[4];
    int nw, ta, tb;
    do_reset();
    req_a = 1'b1; dat_a = 4'b1111; req_b = 1'b1; dat_b = 4'b0101;
    nw = 0; ta = -1; tb = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (dp_ce && nw < 4) begin wr[nw] = dp_d; nw++; end
      if (ack_a) begin ta = t; req_a = 1'b0; end
      if (ack_b) begin tb = t; req_b = 1'b0; end
    end
    compared++; if (nw != 2) begin mismatched++; $display("FAIL tie_count: got %0d want 2", nw); end
    compared++; if (nw >= 2 && (wr[0] !== 4'b1111 || wr[1] !== 4'b0101)) begin mismatched++; $display("FAIL tie_order: got %h,%h want f,5", wr[0], wr[1]); end
    compared++; if (ta != 2 || tb != 6) begin mismatched++; $display("FAIL tie_ack_time: got a=%0d b=%0d want 2 6", ta, tb); end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_contention();
    bit exp_b[5];
    bit got_b[5];
    int n;
`ifdef ROUND_ROBIN_EN
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    req_a = 1'b1; req_b = 1'b1; dat_a = DW'($urandom); dat_b = DW'($urandom);
    n = 0;
    for (int t = 0; t < 40 && n < 5; t++) begin
      @(negedge clk);
      compared++; if (ack_a && ack_b) begin mismatched++; $display("FAIL cont_both_ack: got 11 want not 11"); end
      if (ack_a || ack_b) begin
        got_b[n] = ack_b;
        n++;
        if (n == 4) req_a = 1'b0;
        if (n == 5) req_b = 1'b0;
      end
    end
    compared++; if (n != 5) begin mismatched++; $display("FAIL cont_count: got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        compared++; if (got_b[i] !== exp_b[i]) begin mismatched++; $display("FAIL cont_grant%0d: got %b want %b", i, got_b[i], exp_b[i]); end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ce_t[4];
    logic [DW-1:0] ce_d[4];
    int nce, nack, c0;
    c0 = ce_count;
    req_b = 1'b1; dat_b = 4'b0111;
    nce = 0; nack = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (dp_ce && nce < 4) begin ce_t[nce] = t; ce_d[nce] = dp_d; nce++; end
      if (ack_b) begin
        nack++;
        if (nack == 1) dat_b = 4'b1000;
        if (nack == 2) req_b = 1'b0;
      end
    end
    compared++; if (ce_count - c0 != 2 || nack != 2) begin mismatched++; $display("FAIL b2b_count: got pulses=%0d acks=%0d want 2 2", ce_count - c0, nack); end
    compared++; if (nce >= 2 && (ce_t[0] != 0 || ce_t[1] != 4)) begin mismatched++; $display("FAIL b2b_timing: got %0d,%0d want 0,4", ce_t[0], ce_t[1]); end
    compared++; if (nce >= 2 && (ce_d[0] !== 4'b0111 || ce_d[1] !== 4'b1000)) begin mismatched++; $display("FAIL b2b_data: got %h,%h want 7,8", ce_d[0], ce_d[1]); end
    req_b = 1'b0;
  endtask

  // Reference: a request seen at edge k is accepted if no transaction is in
  // flight (at least 4 edges since the previous acceptance); the write appears
  // in the cycle after edge k and the ack two cycles later.
  task automatic test_random();
    bit sa, sb, win, mown;
    int last_acc;
    logic [DW-1:0] mdat;
    bit e_ce, e_aa, e_ab, e_busy;
    do_reset();
    sa = 1'b0; sb = 1'b0; mown = 1'b1; last_acc = -10; mdat = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k >= last_acc + 4 && (sa || sb)) begin
        if (sa && sb) begin
`ifdef ROUND_ROBIN_EN
          win = ~mown;
`else
          win = 1'b0;
`endif
        end else begin
          win = sb;
        end
        mown = win; last_acc = k;
        mdat = win ? dat_b : dat_a;
      end
      e_ce   = (k == last_acc);
      e_aa   = (k == last_acc + 2) && !mown;
      e_ab   = (k == last_acc + 2) && mown;
      e_busy = (k >= last_acc) && (k <= last_acc + 2);
      compared++; if (dp_ce !== e_ce) begin mismatched++; $display("FAIL rnd_ce@%0d: got %b want %b", k, dp_ce, e_ce); end
      compared++; if ({ack_a, ack_b} !== {e_aa, e_ab}) begin mismatched++; $display("FAIL rnd_ack@%0d: got %b%b want %b%b", k, ack_a, ack_b, e_aa, e_ab); end
      compared++; if (busy !== e_busy) begin mismatched++; $display("FAIL rnd_busy@%0d: got %b want %b", k, busy, e_busy); end
      compared++; if (owner !== mown || dp_d !== mdat || err !== 1'b0) begin mismatched++; $display("FAIL rnd_state@%0d: got owner=%b d=%h err=%b want %b %h 0", k, owner, dp_d, err, mown, mdat); end
      if (ack_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 2) == 0) begin req_a = 1'b1; dat_a = DW'($urandom); end
      if (ack_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin req_b = 1'b1; dat_b = DW'($urandom); end
      sa = req_a; sb = req_b;
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_mismatch();
    test_reset_in_load();
    test_data_change();
    test_tie();
    test_contention();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule
